// File: rtl/apb_arb_pkg.sv
// Shared types for the two-master APB arbiter: FSM states, master indices, grant encoding.
// Optional timeout is enabled in apb_arbiter2 with the APB_ARB_TIMEOUT_EN macro.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_AUX = 1'b1;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-request round-robin pick; on a tie the master that did not win last goes.
// Zero latency; no backpressure (pure function of req_i and last_winner_i).
module rr_arbiter2
    import apb_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_winner_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = onehot2(M_CPU);
            2'b10:   gnt_o = onehot2(M_AUX);
            2'b11:   gnt_o = (last_winner_i == M_CPU) ? onehot2(M_AUX) : onehot2(M_CPU);
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/apb_arbiter2.sv
// Two-master to one-completer APB arbiter; request in IDLE at N gives m_psel at N+1, pready at N+2 earliest.
// Masters are held by the completer's m_pready; optional forced-error timeout under APB_ARB_TIMEOUT_EN.
module apb_arbiter2
    import apb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    rts,
    input  logic [ADDR_WIDTH-1:0]   s0_paddr,
    input  logic [ADDR_WIDTH-1:0]   s1_paddr,
    input  logic [DATA_WIDTH-1:0]   s0_pdata,
    input  logic [DATA_WIDTH-1:0]   s1_pdata,
    input  logic                    s0_psel,
    input  logic                    s1_psel,
    input  logic                    s0_penable,
    input  logic                    s1_penable,
    input  logic                    s0_pwrite,
    input  logic                    s1_pwrite,
    input  logic [DATA_WIDTH/8-1:0] s0_pstb,
    input  logic [DATA_WIDTH/8-1:0] s1_pstb,
    output logic [DATA_WIDTH-1:0]   s0_prdata,
    output logic [DATA_WIDTH-1:0]   s1_prdata,
    output logic                    s0_pready,
    output logic                    s1_pready,
    output logic                    s0_perr,
    output logic                    s1_perr,
    output logic [ADDR_WIDTH-1:0]   m_paddr,
    output logic [DATA_WIDTH-1:0]   m_pdata,
    output logic                    m_psel,
    output logic                    m_penable,
    output logic                    m_pwrite,
    output logic [DATA_WIDTH/8-1:0] m_pstb,
    input  logic [DATA_WIDTH-1:0]   m_prdata,
    input  logic                    m_pready,
    input  logic                    m_perr,
    output logic [1:0]              grant
);

    localparam int SW = DATA_WIDTH / 8;

    if ((DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("apb_arbiter2: DATA_WIDTH must be a multiple of 8 and TIMEOUT_CYCLES >= 1");
    end

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
    logic                  pwrite_q, pwrite_d;
    logic [SW-1:0]         pstb_q, pstb_d;

    logic [1:0] idle_gnt;
    logic       lat_en;
    logic       lat_idx;
    logic       cur_idx;
    logic       other_psel;
    logic       to_hit;
    logic       done;

    // s*_penable carries no arbitration meaning; the arbiter sequences the completer itself.
    logic unused_penable;
    assign unused_penable = s0_penable ^ s1_penable;

    rr_arbiter2 u_rr (
        .req_i         ({s1_psel, s0_psel}),
        .last_winner_i (last_q),
        .gnt_o         (idle_gnt)
    );

`ifdef APB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] cnt_q, cnt_d;

    // Cleared in every non-ACCESS cycle, so each SETUP re-arms it for the next transfer.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q != ACCESS) begin
            cnt_d = '0;
        end else if (!m_pready) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign to_hit = (state_q == ACCESS) && !m_pready && (cnt_q == TO_LIMIT);
`else
    assign to_hit = 1'b0;
`endif

    assign cur_idx    = grant_q[1];
    assign done       = (state_q == ACCESS) && (m_pready || to_hit);
    assign other_psel = cur_idx ? s0_psel : s1_psel;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        last_d   = last_q;
        paddr_d  = paddr_q;
        pdata_d  = pdata_q;
        pwrite_d = pwrite_q;
        pstb_d   = pstb_q;
        lat_en   = 1'b0;
        lat_idx  = M_CPU;

        case (state_q)
            IDLE: begin
                if (|idle_gnt) begin
                    lat_en  = 1'b1;
                    lat_idx = idle_gnt[1];
                    state_d = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (done) begin
                    last_d = cur_idx;
                    // Only the other master may chain; the finisher's own psel waits for IDLE.
                    if (other_psel) begin
                        lat_en  = 1'b1;
                        lat_idx = ~cur_idx;
                        state_d = SETUP;
                    end else begin
                        state_d = IDLE;
                        grant_d = 2'b00;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (lat_en) begin
            grant_d  = onehot2(lat_idx);
            paddr_d  = lat_idx ? s1_paddr  : s0_paddr;
            pdata_d  = lat_idx ? s1_pdata  : s0_pdata;
            pwrite_d = lat_idx ? s1_pwrite : s0_pwrite;
            pstb_d   = lat_idx ? s1_pstb   : s0_pstb;
        end
    end

    always_ff @(posedge clk) begin
        if (rts) begin
            state_q  <= IDLE;
            grant_q  <= 2'b00;
            last_q   <= M_AUX;
            paddr_q  <= '0;
            pdata_q  <= '0;
            pwrite_q <= 1'b0;
            pstb_q   <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            last_q   <= last_d;
            paddr_q  <= paddr_d;
            pdata_q  <= pdata_d;
            pwrite_q <= pwrite_d;
            pstb_q   <= pstb_d;
        end
    end

    assign m_psel    = (state_q != IDLE);
    assign m_penable = (state_q == ACCESS);
    assign m_paddr   = paddr_q;
    assign m_pdata   = pdata_q;
    assign m_pwrite  = pwrite_q;
    assign m_pstb    = pstb_q;
    assign grant     = grant_q;

    assign s0_pready = done && grant_q[0];
    assign s1_pready = done && grant_q[1];
    assign s0_perr   = s0_pready && (m_perr || to_hit);
    assign s1_perr   = s1_pready && (m_perr || to_hit);
    assign s0_prdata = (s0_pready && !to_hit) ? m_prdata : '0;
    assign s1_prdata = (s1_pready && !to_hit) ? m_prdata : '0;

endmodule

// File: tb/tb_apb_arbiter2.sv
// Cycle-table bench for apb_arbiter2 with a scoreboard of expected completer-side transfers.
// Inputs change at negedge, outputs are compared 1 ns later.
module tb_apb_arbiter2;

    logic        clk = 1'b0;
    logic        rts;
    logic [31:0] s0_paddr, s1_paddr, s0_pdata, s1_pdata;
    logic        s0_psel, s1_psel, s0_penable, s1_penable, s0_pwrite, s1_pwrite;
    logic [3:0]  s0_pstb, s1_pstb;
    logic [31:0] s0_prdata, s1_prdata;
    logic        s0_pready, s1_pready, s0_perr, s1_perr;
    logic [31:0] m_paddr, m_pdata, m_prdata;
    logic        m_psel, m_penable, m_pwrite, m_pready, m_perr;
    logic [3:0]  m_pstb;
    logic [1:0]  grant;

    always #5 clk = ~clk;

    apb_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rts(rts),
        .s0_paddr(s0_paddr), .s1_paddr(s1_paddr),
        .s0_pdata(s0_pdata), .s1_pdata(s1_pdata),
        .s0_psel(s0_psel), .s1_psel(s1_psel),
        .s0_penable(s0_penable), .s1_penable(s1_penable),
        .s0_pwrite(s0_pwrite), .s1_pwrite(s1_pwrite),
        .s0_pstb(s0_pstb), .s1_pstb(s1_pstb),
        .s0_prdata(s0_prdata), .s1_prdata(s1_prdata),
        .s0_pready(s0_pready), .s1_pready(s1_pready),
        .s0_perr(s0_perr), .s1_perr(s1_perr),
        .m_paddr(m_paddr), .m_pdata(m_pdata),
        .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
        .m_pstb(m_pstb), .m_prdata(m_prdata),
        .m_pready(m_pready), .m_perr(m_perr),
        .grant(grant)
    );

    typedef struct {
        logic        rst, p0, p1;
        logic [31:0] a0, a1;
        logic        rdy, err;
        logic [31:0] rd;
        logic [1:0]  g;
        logic        sel, en, r0, r1, e0, e1;
        logic [31:0] d0, d1;
    } vec_t;

    typedef struct {
        logic [1:0]  g;
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  s;
    } xfer_t;

    int    checks = 0;
    int    failures = 0;
    xfer_t sbq[$];
    xfer_t cur;
    logic  have_cur = 1'b0;

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_0020;
    localparam logic [31:0] AX = 32'h000F_FFF0;
    localparam logic [31:0] D0 = 32'h0000_C0DE;
    localparam logic [31:0] D1 = 32'h0000_55AA;

    function automatic vec_t mk(input logic rst, p0, p1, input logic [31:0] a0, a1,
                                input logic rdy, err, input logic [31:0] rd, input logic [1:0] g,
                                input logic sel, en, r0, r1, e0, e1, input logic [31:0] d0, d1);
        vec_t v;
        v.rst = rst; v.p0 = p0; v.p1 = p1; v.a0 = a0; v.a1 = a1;
        v.rdy = rdy; v.err = err; v.rd = rd; v.g = g; v.sel = sel; v.en = en;
        v.r0 = r0; v.r1 = r1; v.e0 = e0; v.e1 = e1; v.d0 = d0; v.d1 = d1;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_x(input logic m);
        xfer_t x;
        x.g = m ? 2'b10 : 2'b01;
        x.a = m ? A1 : A0;
        x.w = m;
        x.d = m ? D1 : D0;
        x.s = m ? 4'b0011 : 4'hF;
        sbq.push_back(x);
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        rts = v.rst; s0_psel = v.p0; s1_psel = v.p1;
        s0_paddr = v.a0; s1_paddr = v.a1;
        m_pready = v.rdy; m_perr = v.err; m_prdata = v.rd;
        #1;
        chk("grant", 32'(grant), 32'(v.g));
        chk("m_psel", 32'(m_psel), 32'(v.sel));
        chk("m_penable", 32'(m_penable), 32'(v.en));
        chk("s0_pready", 32'(s0_pready), 32'(v.r0));
        chk("s1_pready", 32'(s1_pready), 32'(v.r1));
        chk("s0_perr", 32'(s0_perr), 32'(v.e0));
        chk("s1_perr", 32'(s1_perr), 32'(v.e1));
        chk("s0_prdata", s0_prdata, v.d0);
        chk("s1_prdata", s1_prdata, v.d1);
        if (m_psel && !m_penable) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_setup", 32'd1, 32'd0);
                have_cur = 1'b0;
            end else begin
                cur = sbq.pop_front();
                have_cur = 1'b1;
                chk("sb_grant", 32'(grant), 32'(cur.g));
            end
        end
        if (m_psel && have_cur) begin
            chk("sb_paddr", m_paddr, cur.a);
            chk("sb_pwrite", 32'(m_pwrite), 32'(cur.w));
            chk("sb_pdata", m_pdata, cur.d);
            chk("sb_pstb", 32'(m_pstb), 32'(cur.s));
        end
    endtask

    vec_t tbl[16];

    initial begin
        rts = 1'b1;
        s0_psel = 0; s1_psel = 0; s0_penable = 0; s1_penable = 0;
        s0_paddr = A0; s1_paddr = A1; s0_pdata = D0; s1_pdata = D1;
        s0_pwrite = 0; s1_pwrite = 1; s0_pstb = 4'hF; s1_pstb = 4'b0011;
        m_pready = 0; m_perr = 0; m_prdata = 0;

        //             rst p0 p1 a0        a1  rdy err rd             g      sel en r0 r1 e0 e1 d0             d1
        tbl[0]  = mk(0, 0, 0, A0,        A1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[1]  = mk(0, 1, 1, A0,        A1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[2]  = mk(0, 1, 1, A0,        A1, 1, 0, 32'hBAD0BAD0,  2'b01, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[3]  = mk(0, 1, 1, A0,        A1, 1, 0, 32'h11111111,  2'b01, 1, 1, 1, 0, 0, 0, 32'h11111111,  32'h0);
        tbl[4]  = mk(0, 0, 1, A0,        A1, 0, 0, 32'h0,         2'b10, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[5]  = mk(0, 0, 0, A0,        AX, 0, 0, 32'hAAAA0000,  2'b10, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[6]  = mk(0, 1, 0, A0,        AX, 0, 1, 32'hAAAA0000,  2'b10, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[7]  = mk(0, 1, 0, A0,        AX, 0, 0, 32'h0,         2'b10, 1, 1, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[8]  = mk(0, 1, 0, A0,        AX, 1, 1, 32'h12345678,  2'b10, 1, 1, 0, 1, 0, 1, 32'h0,         32'h12345678);
        tbl[9]  = mk(0, 1, 0, 32'h2000,  AX, 0, 0, 32'h0,         2'b01, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[10] = mk(0, 1, 0, 32'h2000,  A1, 1, 0, 32'hDEADBEEF,  2'b01, 1, 1, 1, 0, 0, 0, 32'hDEADBEEF,  32'h0);
        tbl[11] = mk(0, 0, 0, A0,        A1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[12] = mk(0, 1, 0, A0,        A1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[13] = mk(0, 0, 0, A0,        A1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 0, 0, 0, 32'h0,         32'h0);
        tbl[14] = mk(0, 0, 0, A0,        A1, 1, 0, 32'hDEADBEEF,  2'b01, 1, 1, 1, 0, 0, 0, 32'hDEADBEEF,  32'h0);
        tbl[15] = mk(0, 0, 0, A0,        A1, 1, 0, 32'hDEADBEEF,  2'b00, 0, 0, 0, 0, 0, 0, 32'h0,         32'h0);

        repeat (2) @(negedge clk);

        push_x(1'b0); push_x(1'b1); push_x(1'b0); push_x(1'b0);
        for (int i = 0; i < 16; i++) step(tbl[i]);

        // Fairness: both masters request continuously for six transfers after a reset.
        step(mk(1, 0, 0, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 6; k++) push_x(k[0]);
        step(mk(0, 1, 1, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 6; k++) begin
            logic [1:0]  g;
            logic [31:0] rd;
            g  = k[0] ? 2'b10 : 2'b01;
            rd = 32'hF000_0000 + 32'(k);
            step(mk(0, 1, 1, A0, A1, 0, 0, 0, g, 1, 0, 0, 0, 0, 0, 0, 0));
            step(mk(0, (k != 5), 1, A0, A1, 1, 0, rd, g, 1, 1, g[0], g[1], 0, 0,
                    g[0] ? rd : 32'h0, g[1] ? rd : 32'h0));
        end
        step(mk(0, 0, 0, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

        // Reset during ACCESS abandons the transfer; a late m_pready afterwards is ignored.
        push_x(1'b0);
        step(mk(0, 1, 0, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, A0, A1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(1, 0, 0, A0, A1, 0, 0, 0, 2'b01, 1, 1, 0, 0, 0, 0, 0, 0));
        have_cur = 1'b0;
        step(mk(0, 0, 0, A0, A1, 1, 0, 32'h5A5A5A5A, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        push_x(1'b0);
        step(mk(0, 1, 0, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, A0, A1, 0, 0, 0, 2'b01, 1, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, A0, A1, 1, 0, 32'h0BADF00D, 2'b01, 1, 1, 1, 0, 0, 0, 32'h0BADF00D, 0));
        step(mk(0, 0, 0, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));

`ifdef APB_ARB_TIMEOUT_EN
        // Four unanswered ACCESS cycles, then a forced error response.
        push_x(1'b1);
        step(mk(0, 0, 1, A0, A1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, A0, A1, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 4; k++)
            step(mk(0, 0, 0, A0, A1, 0, 0, 32'h77777777, 2'b10, 1, 1, 0, 0, 0, 0, 0, 0));
        step(mk(0, 0, 0, A0, A1, 0, 0, 32'h77777777, 2'b10, 1, 1, 0, 1, 0, 1, 0, 0));
        step(mk(0, 0, 0, A0, A1, 1, 0, 32'h77777777, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0));
`endif

        chk("sb_leftover", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
